fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter DEPTH, default 2, prefetch buffer entries and maximum in-flight plus buffered words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address, bits [1:0] always 00.
REQ-007 imem_gnt  input  1  memory accepts the request this cycle (only meaningful with imem_req=1).
REQ-008 imem_rvalid  input  1  read data valid; responses return in request order, at least 1 cycle after grant.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 redirect_valid  input  1  core requests a PC change (branch/jump).
REQ-011 redirect_pc  input  32  new fetch target; bits [1:0] ignored, treated as 00.
REQ-012 insn_valid  output  1  instruction available to the core.
REQ-013 insn  output  32  instruction word at buffer head.
REQ-014 insn_pc  output  32  address of insn.
REQ-015 insn_ready  input  1  core consumes insn when insn_valid and insn_ready are both 1.

Function
REQ-016 State machine SHALL have two states: FETCH (issue requests) and DRAIN (discard stale in-flight responses, no requests).
REQ-017 Registers: fetch_pc (32), outstanding counter (0..DEPTH), FIFO of DEPTH entries {insn, pc} with head/tail pointers and count (0..DEPTH), discard counter (0..DEPTH).
REQ-018 imem_req SHALL equal (state==FETCH) and (outstanding + count < DEPTH) and not redirect_valid; imem_addr SHALL equal fetch_pc.
REQ-019 On imem_req & imem_gnt: fetch_pc += 4 (mod 2^32 wrap), outstanding += 1, pc of the request queued in order for its response.
REQ-020 On imem_rvalid with discard = 0: write {imem_rdata, pc} to FIFO tail, outstanding -= 1; the REQ-018 credit rule guarantees the FIFO is never full at this point.
REQ-021 On imem_rvalid with discard > 0: drop data, discard -= 1, outstanding -= 1.
REQ-022 imem_rvalid with outstanding = 0 SHALL be ignored with no state change.
REQ-023 insn_valid SHALL equal (count > 0) and not redirect_valid; insn/insn_pc SHALL show FIFO head; head pops on insn_valid & insn_ready.
REQ-024 Simultaneous grant, response, and pop in one cycle SHALL update outstanding and count by net effect, without loss.
REQ-025 On redirect_valid: FIFO flushed (count = 0), fetch_pc = {redirect_pc[31:2],2'b00}, discard = outstanding minus any response not dropped this cycle (a response arriving in the redirect cycle is dropped); next state DRAIN if resulting discard > 0, else FETCH.
REQ-026 Redirect while in DRAIN SHALL reload fetch_pc and stay in DRAIN; discard unchanged apart from responses dropped.
REQ-027 DRAIN -> FETCH in the cycle after discard reaches 0; first request then uses the latest redirect target.
REQ-028 Full buffer (outstanding + count = DEPTH) SHALL hold imem_req low until a pop frees an entry.

Reset
REQ-029 While reset = 0: state = FETCH, fetch_pc = RESET_PC, outstanding = count = discard = 0, imem_req = 0, insn_valid = 0, insn = 0, insn_pc = 0.
REQ-030 Reset asserted mid-operation SHALL immediately abandon in-flight requests; responses to requests issued before reset are not guaranteed to be discarded, and the memory side SHALL be reset together with this block.
REQ-031 First cycle after reset release: imem_req = 1, imem_addr = RESET_PC.

Verification
REQ-032 Reset release, imem_gnt = 1, rvalid 1 cycle after each grant with rdata = 32'h02A08093, 32'h01510113, 32'h4020F1B3, insn_ready = 1 -> insn_pc 0,4,8 delivered in order with matching insn.
REQ-033 insn_ready = 0, memory always granting -> exactly 2 grants (addr 0, 4), then imem_req = 0 while count = 2; raise insn_ready -> requests resume at addr 8.
REQ-034 Two requests outstanding, redirect_valid with redirect_pc = 32'h0000_0103 -> FIFO flushed, DRAIN, both responses dropped, next request addr 32'h0000_0100, insn_pc of next delivered word = 32'h100.
REQ-035 Redirect in the same cycle as an imem_rvalid -> that word never appears on insn; no duplicate or missing instruction after the target.
REQ-036 fetch_pc = 32'hFFFF_FFFC granted -> next imem_addr = 32'h0000_0000.
REQ-037 reset pulsed low with 1 request outstanding and count = 1 -> insn_valid = 0 and imem_req = 0 immediately, imem_addr = RESET_PC after release.

Source files
------------

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end. Issues word fetches under a credit
//            limit, buffers responses in a small FIFO for the core, and
//            discards stale in-flight responses after a redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,            // asynchronous, active low
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_insn_valid,
  output logic [31:0] o_insn,
  output logic [31:0] o_insn_pc,
  input  logic        i_insn_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_fetch_pc, w_fetch_pc_nxt;
  logic [CW-1:0]   r_outstanding, w_outstanding_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [CW-1:0]   r_discard, w_discard_nxt;
  logic [PW-1:0]   r_head, r_tail;
  logic [31:0]     r_fifo_insn [DEPTH];
  logic [31:0]     r_fifo_pc   [DEPTH];

  logic            w_credit, w_req, w_grant;
  logic            w_rsp, w_drop, w_push;
  logic            w_insn_valid, w_pop;
  logic [31:0]     w_rsp_pc, w_redirect_target;

  // Circular pointer advance that also works for non power-of-two depths.
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // In-flight plus buffered words must leave room for every response.
  assign w_credit = ({1'b0, r_outstanding} + {1'b0, r_count}) < (CW+1)'(DEPTH);
  assign w_req    = reset & (r_state == ST_FETCH) & w_credit & ~i_redirect_valid;
  assign w_grant  = w_req & i_imem_gnt;

  // A response with nothing in flight is spurious and ignored entirely.
  assign w_rsp  = i_imem_rvalid & (r_outstanding != '0);
  assign w_drop = w_rsp & ((r_discard != '0) | i_redirect_valid);
  assign w_push = w_rsp & ~w_drop;

  assign w_insn_valid = (r_count != '0) & ~i_redirect_valid;
  assign w_pop        = w_insn_valid & i_insn_ready;

  // Non-discarded in-flight requests are contiguous and end at fetch_pc-4,
  // so the oldest one's address follows from the outstanding count.
  assign w_rsp_pc          = r_fetch_pc - (32'(r_outstanding) << 2);
  assign w_redirect_target = i_redirect_pc & ~32'h0000_0003;

  assign o_imem_req   = w_req;
  assign o_imem_addr  = r_fetch_pc;
  assign o_insn_valid = w_insn_valid;
  assign o_insn       = (r_count != '0) ? r_fifo_insn[r_head] : '0;
  assign o_insn_pc    = (r_count != '0) ? r_fifo_pc[r_head]   : '0;

  // Next-state: counters by net effect, redirect flushes and re-targets.
  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_outstanding_nxt = r_outstanding + CW'(w_grant) - CW'(w_rsp);
    w_count_nxt       = r_count + CW'(w_push) - CW'(w_pop);
    w_discard_nxt     = r_discard - CW'(w_rsp & (r_discard != '0));
    if (i_redirect_valid) begin
      // Everything still in flight becomes stale (no grant this cycle).
      w_fetch_pc_nxt = w_redirect_target;
      w_count_nxt    = '0;
      w_discard_nxt  = w_outstanding_nxt;
    end else if (w_grant) begin
      w_fetch_pc_nxt = r_fetch_pc + 32'd4;
    end
    w_state_nxt = (w_discard_nxt != '0) ? ST_DRAIN : ST_FETCH;
  end

  // State, fetch address and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_FETCH;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_count       <= '0;
      r_discard     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_count       <= w_count_nxt;
      r_discard     <= w_discard_nxt;
    end
  end

  // Prefetch FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_insn[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (i_redirect_valid) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) begin
        r_fifo_insn[r_tail] <= i_imem_rdata;
        r_fifo_pc[r_tail]   <= w_rsp_pc;
        r_tail              <= f_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= f_inc(r_head);
      end
    end
  end

endmodule
`default_nettype wire
